// File: rtl/axis_addr_bram_reader.sv
// Streams BRAM words for incoming AXI-Stream addresses through a 3-entry skid FIFO.
// Optional AXIS_ADDR_BRAM_READER_TLAST_EN adds cfg_last / m_axis_tlast marking a chosen address.
module axis_addr_bram_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [BRAM_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
`ifdef AXIS_ADDR_BRAM_READER_TLAST_EN
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_last,
  output logic                        m_axis_tlast,
`endif
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic                        bram_porta_en,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata
);

  localparam int DEPTH = 3;

  logic                       rd_pend_q, rd_pend_d;
  logic [1:0]                 count_q, count_d;
  logic [BRAM_DATA_WIDTH-1:0] data_q [DEPTH];
  logic [BRAM_DATA_WIDTH-1:0] data_d [DEPTH];
  logic [2:0]                 used;
  logic [1:0]                 wrIdx;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic                       unused_upper;

  assign bram_porta_clk = aclk;
  assign bram_porta_rst = areset;

  // Credit covers both the read in flight and buffered words, so a push never finds the FIFO full
  assign used          = {2'b00, rd_pend_q} + {1'b0, count_q};
  assign s_axis_tready = ~areset & (used < 3'd3);

  assign accept          = s_axis_tvalid & s_axis_tready;
  assign bram_porta_en   = accept;
  assign bram_porta_addr = s_axis_tdata[BRAM_ADDR_WIDTH-1:0];
  assign unused_upper    = ^s_axis_tdata;

  assign push          = rd_pend_q;
  assign m_axis_tvalid = (count_q != 2'd0);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = data_q[0];
  assign wrIdx         = count_q - {1'b0, pop};

  // Head lives at entry 0; a pop shifts down, a push lands just behind the last live entry
  always_comb begin
    rd_pend_d = accept;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wrIdx == 2'(i))) begin
        data_d[i] = bram_porta_rddata;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_pend_q <= 1'b0;
      count_q   <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      rd_pend_q <= rd_pend_d;
      count_q   <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

`ifdef AXIS_ADDR_BRAM_READER_TLAST_EN
  logic             last_pend_q, last_pend_d;
  logic [DEPTH-1:0] last_q, last_d;

  // The flag is captured at accept time and travels alongside its word
  always_comb begin
    last_pend_d = (bram_porta_addr == cfg_last);
    last_d      = last_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        last_d[i] = last_q[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wrIdx == 2'(i))) begin
        last_d[i] = last_pend_q;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      last_pend_q <= 1'b0;
      last_q      <= '0;
    end else begin
      last_pend_q <= last_pend_d;
      last_q      <= last_d;
    end
  end

  assign m_axis_tlast = last_q[0];
`endif

endmodule

// File: tb/tb_axis_addr_bram_reader.sv
// Scoreboard bench for axis_addr_bram_reader; BRAM model holds word i*3 at address i.
module tb_axis_addr_bram_reader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 10;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          bram_porta_clk;
  logic          bram_porta_rst;
  logic          bram_porta_en;
  logic [BW-1:0] bram_porta_addr;
  logic [DW-1:0] bram_porta_rddata;
  logic [BW-1:0] cfg_last;
`ifdef AXIS_ADDR_BRAM_READER_TLAST_EN
  logic          m_axis_tlast;
`endif

  axis_addr_bram_reader #(
    .AXIS_TDATA_WIDTH(AW),
    .BRAM_DATA_WIDTH (DW),
    .BRAM_ADDR_WIDTH (BW)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
`ifdef AXIS_ADDR_BRAM_READER_TLAST_EN
    .cfg_last         (cfg_last),
    .m_axis_tlast     (m_axis_tlast),
`endif
    .bram_porta_clk   (bram_porta_clk),
    .bram_porta_rst   (bram_porta_rst),
    .bram_porta_en    (bram_porta_en),
    .bram_porta_addr  (bram_porta_addr),
    .bram_porta_rddata(bram_porta_rddata)
  );

  always #5 aclk = ~aclk;

  logic [DW-1:0] bram [1024];
  initial begin
    for (int i = 0; i < 1024; i++) bram[i] = 32'(i * 3);
  end

  always @(posedge aclk) begin
    if (bram_porta_en) bram_porta_rddata <= bram[bram_porta_addr];
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            accCyc;
  } exp_t;

  exp_t   sbQ[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     chkLatency = 1'b0;
  int     nextAddr;
  int     remaining;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected words are queued from the address handshake using the bench's own BRAM image
  always @(negedge aclk) begin
    exp_t e;
    if (areset) begin
      sbQ.delete();
    end else if (s_axis_tvalid && s_axis_tready) begin
      e.data   = bram[s_axis_tdata[BW-1:0]];
      e.last   = (s_axis_tdata[BW-1:0] == cfg_last);
      e.accCyc = cyc;
      sbQ.push_back(e);
    end
  end

  // Output monitor: held head is compared every stalled cycle, popped on handshake
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_word", {32'd0, m_axis_tdata}, 64'hdead_0000_0000_0000);
      end else begin
        checkOutput("m_tdata", {32'd0, m_axis_tdata}, {32'd0, sbQ[0].data});
`ifdef AXIS_ADDR_BRAM_READER_TLAST_EN
        checkOutput("m_tlast", {63'd0, m_axis_tlast}, {63'd0, sbQ[0].last});
`endif
        if (m_axis_tready) begin
          if (chkLatency) checkOutput("latency", 64'(cyc - sbQ[0].accCyc), 64'd2);
          void'(sbQ.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int vPct, input int rPct);
    s_axis_tvalid = (remaining > 0) && ($urandom_range(99) < vPct);
    s_axis_tdata  = nextAddr;
    m_axis_tready = ($urandom_range(99) < rPct);
    @(negedge aclk);
    if (s_axis_tvalid && s_axis_tready) begin
      nextAddr++;
      remaining--;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic runUntilDone(input int vPct, input int rPct, output int used);
    used = 0;
    while (remaining > 0 && used < 20000) begin
      applyStimulus(vPct, rPct);
      used++;
    end
    if (remaining > 0) checkOutput("stream_timeout", 64'(remaining), 64'd0);
  endtask

  task automatic drain(input int rPct);
    int budget = 200;
    while ((sbQ.size() != 0 || m_axis_tvalid) && budget > 0) begin
      applyStimulus(0, rPct);
      budget--;
    end
    if (budget == 0) checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    int used;
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    cfg_last      = 10'd1000;
    remaining     = 0;
    nextAddr      = 0;
    repeat (3) @(posedge aclk);
    #1;

    @(negedge aclk);
    checkOutput("rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    checkOutput("rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
    checkOutput("rst_en", {63'd0, bram_porta_en}, 64'd0);
    checkOutput("rst_m_tdata", {32'd0, m_axis_tdata}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("post_rst_s_tready", {63'd0, s_axis_tready}, 64'd1);
    @(posedge aclk);
    #1;

    // Back-to-back 0..15 at full rate with fixed two-cycle latency
    $display("[TB] back-to-back stream");
    chkLatency = 1'b1;
    nextAddr   = 0;
    remaining  = 16;
    runUntilDone(100, 100, used);
    checkOutput("b2b_cycles", 64'(used), 64'd16);
    drain(100);
    chkLatency = 1'b0;

    // Backpressure: three words buffered, input throttled, head held
    $display("[TB] backpressure");
    nextAddr  = 300;
    remaining = 20;
    repeat (10) applyStimulus(100, 0);
    @(negedge aclk);
    checkOutput("bp_accepted", 64'(remaining), 64'd17);
    checkOutput("bp_s_tready", {63'd0, s_axis_tready}, 64'd0);
    checkOutput("bp_m_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    checkOutput("bp_head", {32'd0, m_axis_tdata}, 64'd900);
    @(posedge aclk);
    #1;
    runUntilDone(100, 100, used);
    drain(100);

    // Upper address bits are ignored
    $display("[TB] address truncation");
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0000_0405;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    checkOutput("trunc_addr", {54'd0, bram_porta_addr}, 64'h005);
    checkOutput("trunc_en", {63'd0, bram_porta_en}, 64'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    drain(100);

    // Random handshakes over 1000 counter addresses crossing 1023 -> 0
    $display("[TB] random stream with wrap");
    nextAddr  = 600;
    remaining = 1000;
    runUntilDone(50, 50, used);
    drain(50);

    // Reset with two words buffered and one read in flight
    $display("[TB] mid-stream reset");
    nextAddr  = 100;
    remaining = 3;
    runUntilDone(100, 0, used);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    checkOutput("pre_rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
    checkOutput("pre_rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("mid_rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    checkOutput("mid_rst_m_tdata", {32'd0, m_axis_tdata}, 64'd0);
    checkOutput("mid_rst_s_tready", {63'd0, s_axis_tready}, 64'd1);
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    checkOutput("flushed_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    @(posedge aclk);
    #1;
    nextAddr  = 200;
    remaining = 8;
    runUntilDone(100, 100, used);
    drain(100);

`ifdef AXIS_ADDR_BRAM_READER_TLAST_EN
    $display("[TB] tlast marking");
    cfg_last  = 10'd7;
    nextAddr  = 0;
    remaining = 10;
    runUntilDone(100, 50, used);
    drain(50);
`endif

    checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
